// File: rtl/t_ff_pkg.sv
// Shared definitions for the T flip-flop counter bank: mode encoding and helpers.
package t_ff_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_TOGGLE = 2'b00;
    localparam mode_t MODE_UP     = 2'b01;
    localparam mode_t MODE_DOWN   = 2'b10;
    localparam mode_t MODE_LOAD   = 2'b11;

    // True when the mode moves the register as a binary counter.
    function automatic logic is_count_mode(input mode_t m);
        return (m == MODE_UP) || (m == MODE_DOWN);
    endfunction

endpackage

// File: rtl/t_ff_cell.sv
// Single-bit T flip-flop: toggles on a rising edge when t=1, async active-low reset to rst_val.
module t_ff_cell (
    input  logic clk,
    input  logic reset_n,
    input  logic rst_val,
    input  logic t,
    output logic q,
    output logic qb
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= rst_val;
        end else begin
            q <= q ^ t;
        end
    end

    assign qb = ~q;

endmodule

// File: rtl/t_ff_counter.sv
// WIDTH-bit toggle/up/down/load register built from T cells; every update is a per-bit toggle vector.
module t_ff_counter
    import t_ff_pkg::*;
#(
    parameter int               WIDTH     = 4,
    parameter bit               SATURATE  = 1'b0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             clr,
    input  mode_t            mode,
    input  logic [WIDTH-1:0] t,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             tc,
    output logic             ovf
);

    logic [WIDTH-1:0] te;
    logic [WIDTH-1:0] up_te;
    logic [WIDTH-1:0] dn_te;
    logic             at_max;
    logic             at_min;
    logic             boundary;

    // Ripple-carry toggle enables: bit i flips when all lower bits are 1 (up) or 0 (down).
    always_comb begin
        logic up_carry;
        logic dn_carry;
        up_te    = '0;
        dn_te    = '0;
        up_carry = 1'b1;
        dn_carry = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            up_te[i] = up_carry;
            dn_te[i] = dn_carry;
            up_carry = up_carry & q[i];
            dn_carry = dn_carry & ~q[i];
        end
    end

    assign at_max = &q;
    assign at_min = ~|q;

    always_comb begin
        te       = '0;
        boundary = 1'b0;
        if (clr) begin
            // Clearing is toggling every bit that is currently set.
            te = q;
        end else if (en) begin
            case (mode)
                MODE_TOGGLE: te = t;
                MODE_UP: begin
                    boundary = at_max;
                    te       = (at_max && SATURATE) ? '0 : up_te;
                end
                MODE_DOWN: begin
                    boundary = at_min;
                    te       = (at_min && SATURATE) ? '0 : dn_te;
                end
                MODE_LOAD:   te = q ^ load_val;
                default:     te = '0;
            endcase
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        t_ff_cell u_cell (
            .clk     (clk),
            .reset_n (reset_n),
            .rst_val (RESET_VAL[i]),
            .t       (te[i]),
            .q       (q[i]),
            .qb      (qb[i])
        );
    end

    // boundary is only ever raised for an enabled UP/DOWN edge without clr.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tc  <= 1'b0;
            ovf <= 1'b0;
        end else if (clr) begin
            tc  <= 1'b0;
            ovf <= 1'b0;
        end else begin
            tc <= boundary && is_count_mode(mode);
            if (boundary) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_t_ff_counter.sv
// Directed, table-driven bench for t_ff_counter over three builds (wrap, saturate, 1-bit).
module tb_t_ff_counter;
    import t_ff_pkg::*;

    typedef struct {
        logic [1:0] sel;      // 0: wrap build, 1: saturate build, 2: 1-bit build
        mode_t      mode;
        logic       en;
        logic       clr;
        logic [3:0] t;
        logic [3:0] lv;
        logic [3:0] exp_q;
        logic       exp_tc;
        logic       exp_ovf;
    } vec_t;

    localparam logic [3:0] RV5 = 4'h5;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    logic en_a = 0, clr_a = 0, en_b = 0, clr_b = 0, en_c = 0, clr_c = 0;
    mode_t mode_a = MODE_TOGGLE, mode_b = MODE_TOGGLE, mode_c = MODE_TOGGLE;
    logic [3:0] t_a = '0, lv_a = '0, t_b = '0, lv_b = '0;
    logic       t_c = 0, lv_c = 0;
    logic [3:0] q_a, qb_a, q_b, qb_b;
    logic       q_c, qb_c;
    logic       tc_a, ovf_a, tc_b, ovf_b, tc_c, ovf_c;

    int n_tests = 0;
    int n_fail  = 0;
    logic [3:0] exp_q[$];
    vec_t vecs[$];

    t_ff_counter #(.WIDTH(4), .SATURATE(1'b0), .RESET_VAL(4'h0)) dut_a (
        .clk(clk), .reset_n(reset_n), .en(en_a), .clr(clr_a), .mode(mode_a),
        .t(t_a), .load_val(lv_a), .q(q_a), .qb(qb_a), .tc(tc_a), .ovf(ovf_a)
    );

    t_ff_counter #(.WIDTH(4), .SATURATE(1'b1), .RESET_VAL(4'h0)) dut_b (
        .clk(clk), .reset_n(reset_n), .en(en_b), .clr(clr_b), .mode(mode_b),
        .t(t_b), .load_val(lv_b), .q(q_b), .qb(qb_b), .tc(tc_b), .ovf(ovf_b)
    );

    t_ff_counter #(.WIDTH(1), .SATURATE(1'b0), .RESET_VAL(RV5[0:0])) dut_c (
        .clk(clk), .reset_n(reset_n), .en(en_c), .clr(clr_c), .mode(mode_c),
        .t(t_c), .load_val(lv_c), .q(q_c), .qb(qb_c), .tc(tc_c), .ovf(ovf_c)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // scoreboard: pops the expected q and compares the selected build's outputs
    task automatic check_dut(input logic [1:0] sel, input logic etc, input logic eovf, input string tag);
        logic [3:0] e;
        e = exp_q.pop_front();
        case (sel)
            2'd0: begin
                check({tag, " q_a"},   q_a,  e);
                check({tag, " qb_a"},  qb_a, ~e);
                check({tag, " tc_a"},  {3'b0, tc_a},  {3'b0, etc});
                check({tag, " ovf_a"}, {3'b0, ovf_a}, {3'b0, eovf});
            end
            2'd1: begin
                check({tag, " q_b"},   q_b,  e);
                check({tag, " qb_b"},  qb_b, ~e);
                check({tag, " tc_b"},  {3'b0, tc_b},  {3'b0, etc});
                check({tag, " ovf_b"}, {3'b0, ovf_b}, {3'b0, eovf});
            end
            default: begin
                check({tag, " q_c"},   {3'b0, q_c},  {3'b0, e[0]});
                check({tag, " qb_c"},  {3'b0, qb_c}, {3'b0, ~e[0]});
                check({tag, " tc_c"},  {3'b0, tc_c},  {3'b0, etc});
                check({tag, " ovf_c"}, {3'b0, ovf_c}, {3'b0, eovf});
            end
        endcase
    endtask

    task automatic add(input logic [1:0] sel, input mode_t m, input logic e, input logic c,
                       input logic [3:0] tv, input logic [3:0] lv,
                       input logic [3:0] eq, input logic etc, input logic eovf);
        vec_t v;
        v.sel = sel; v.mode = m; v.en = e; v.clr = c; v.t = tv; v.lv = lv;
        v.exp_q = eq; v.exp_tc = etc; v.exp_ovf = eovf;
        vecs.push_back(v);
    endtask

    // driver: one vector per rising edge, outputs sampled 1 time unit later
    task automatic apply(input vec_t v, input int idx);
        en_a = 0; clr_a = 0; en_b = 0; clr_b = 0; en_c = 0; clr_c = 0;
        case (v.sel)
            2'd0: begin en_a = v.en; clr_a = v.clr; mode_a = v.mode; t_a = v.t; lv_a = v.lv; end
            2'd1: begin en_b = v.en; clr_b = v.clr; mode_b = v.mode; t_b = v.t; lv_b = v.lv; end
            default: begin en_c = v.en; clr_c = v.clr; mode_c = v.mode; t_c = v.t[0]; lv_c = v.lv[0]; end
        endcase
        exp_q.push_back(v.exp_q);
        @(posedge clk);
        #1;
        check_dut(v.sel, v.exp_tc, v.exp_ovf, $sformatf("vec%0d", idx));
    endtask

    task automatic run_table();
        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);
        vecs.delete();
    endtask

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(4'h0); check_dut(2'd0, 1'b0, 1'b0, "reset");
        exp_q.push_back(4'h0); check_dut(2'd1, 1'b0, 1'b0, "reset");
        exp_q.push_back(4'h1); check_dut(2'd2, 1'b0, 1'b0, "reset");
        reset_n = 1'b1;

        // toggle phase on the wrap build
        add(0, MODE_TOGGLE, 1, 0, 4'hA, 4'h0, 4'hA, 0, 0);
        add(0, MODE_TOGGLE, 1, 0, 4'hA, 4'h0, 4'h0, 0, 0);
        add(0, MODE_TOGGLE, 1, 0, 4'hA, 4'h0, 4'hA, 0, 0);
        run_table();

        // asynchronous reset mid-cycle, no clock edge in between
        #2;
        reset_n = 1'b0;
        #1;
        exp_q.push_back(4'h0); check_dut(2'd0, 1'b0, 1'b0, "async_rst");
        @(posedge clk);
        #1;
        exp_q.push_back(4'h0); check_dut(2'd0, 1'b0, 1'b0, "rst_held");
        exp_q.push_back(4'h1); check_dut(2'd2, 1'b0, 1'b0, "rst_held");
        reset_n = 1'b1;

        // up-count wrap, hold/clear priority, load then up, down wrap
        for (int i = 1; i < 16; i++) add(0, MODE_UP, 1, 0, 4'h0, 4'h0, 4'(i), 0, 0);
        add(0, MODE_UP,     1, 0, 4'h0, 4'h0, 4'h0, 1, 1);
        add(0, MODE_UP,     1, 0, 4'h0, 4'h0, 4'h1, 0, 1);
        add(0, MODE_LOAD,   1, 0, 4'h0, 4'h9, 4'h9, 0, 1);
        for (int i = 0; i < 3; i++) add(0, MODE_UP, 0, 0, 4'h0, 4'h0, 4'h9, 0, 1);
        add(0, MODE_UP,     0, 1, 4'h0, 4'h0, 4'h0, 0, 0);
        add(0, MODE_LOAD,   1, 0, 4'h0, 4'hE, 4'hE, 0, 0);
        add(0, MODE_UP,     1, 0, 4'h0, 4'h0, 4'hF, 0, 0);
        add(0, MODE_UP,     1, 0, 4'h0, 4'h0, 4'h0, 1, 1);
        add(0, MODE_UP,     1, 0, 4'h0, 4'h0, 4'h1, 0, 1);
        add(0, MODE_DOWN,   1, 0, 4'h0, 4'h0, 4'h0, 0, 1);
        add(0, MODE_DOWN,   1, 0, 4'h0, 4'h0, 4'hF, 1, 1);
        add(0, MODE_DOWN,   1, 0, 4'h0, 4'h0, 4'hE, 0, 1);
        add(0, MODE_TOGGLE, 1, 0, 4'h5, 4'h0, 4'hB, 0, 1);
        add(0, MODE_UP,     1, 1, 4'h0, 4'h0, 4'h0, 0, 0);

        // saturating build: down holds at 0, up holds at F, tc repeats while held
        add(1, MODE_LOAD,   1, 0, 4'h0, 4'h2, 4'h2, 0, 0);
        add(1, MODE_DOWN,   1, 0, 4'h0, 4'h0, 4'h1, 0, 0);
        add(1, MODE_DOWN,   1, 0, 4'h0, 4'h0, 4'h0, 0, 0);
        add(1, MODE_DOWN,   1, 0, 4'h0, 4'h0, 4'h0, 1, 1);
        add(1, MODE_DOWN,   1, 0, 4'h0, 4'h0, 4'h0, 1, 1);
        add(1, MODE_DOWN,   0, 0, 4'h0, 4'h0, 4'h0, 0, 1);
        add(1, MODE_LOAD,   1, 0, 4'h0, 4'hE, 4'hE, 0, 1);
        add(1, MODE_UP,     1, 0, 4'h0, 4'h0, 4'hF, 0, 1);
        add(1, MODE_UP,     1, 0, 4'h0, 4'h0, 4'hF, 1, 1);
        add(1, MODE_UP,     1, 0, 4'h0, 4'h0, 4'hF, 1, 1);

        // 1-bit build, reset value bit 0 of 4'h5
        add(2, MODE_UP,     1, 0, 4'h0, 4'h0, 4'h0, 1, 1);
        add(2, MODE_UP,     1, 0, 4'h0, 4'h0, 4'h1, 0, 1);
        add(2, MODE_DOWN,   1, 0, 4'h0, 4'h0, 4'h0, 0, 1);
        add(2, MODE_DOWN,   1, 0, 4'h0, 4'h0, 4'h1, 1, 1);
        add(2, MODE_DOWN,   1, 1, 4'h0, 4'h0, 4'h0, 0, 0);
        add(2, MODE_TOGGLE, 1, 0, 4'h1, 4'h0, 4'h1, 0, 0);
        run_table();

        // final report
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/t_ff_counter.md
Name: t_ff_counter

Overview:
- Parametrised successor to the single-bit T flip-flop: a WIDTH-bit register built entirely from T flip-flop cells.
- Per-cycle modes: per-bit toggle, binary up-count, binary down-count, parallel load.
- Adds a synchronous clear, a wrap/saturate option, a one-cycle terminal-count pulse and a sticky overflow flag.
- Used as a general counter/toggle bank in the sequential-logic library; every state change is expressed as a per-bit toggle enable.

Parameters:
- WIDTH, 4, number of T flip-flop bits (minimum 1).
- SATURATE, 0, 0: counters wrap at the boundary; 1: counters hold at all-ones (up) or all-zeros (down).
- RESET_VAL, 0, value of q after reset (WIDTH bits).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- en  input  1  clock enable; when 0 all state holds except clr.
- clr  input  1  synchronous clear; q goes to 0, ovf goes to 0.
- mode  input  2  00 TOGGLE, 01 UP, 10 DOWN, 11 LOAD.
- t  input  WIDTH  per-bit toggle request (TOGGLE mode only).
- load_val  input  WIDTH  parallel load value (LOAD mode only).
- q  output  WIDTH  register state.
- qb  output  WIDTH  bitwise complement of q, always equal to ~q.
- tc  output  1  registered terminal-count pulse.
- ovf  output  1  sticky boundary-event flag.

Behaviour:
- Reset (reset_n=0, asynchronous, any time including mid-count):
  - q=RESET_VAL, qb=~RESET_VAL, tc=0, ovf=0.
  - Release is synchronous to the next rising edge; the first update happens on the first rising edge with reset_n=1.
- Priority per rising edge: clr > (en=0 hold) > mode.
- clr=1: q<=0, ovf<=0, tc<=0, regardless of en and mode.
- en=0 and clr=0: q and ovf hold; tc<=0.
- Each bit i is a T cell: q[i] <= q[i] ^ te[i]. The control logic computes the toggle vector te.
- TOGGLE: te = t. tc<=0.
- UP:
  - te[0]=1; te[i] = AND of q[i-1:0].
  - Boundary: q all-ones. With SATURATE=0, q wraps to 0. With SATURATE=1, te=0 and q holds at all-ones.
- DOWN:
  - te[0]=1; te[i] = AND of ~q[i-1:0].
  - Boundary: q all-zeros. With SATURATE=0, q wraps to all-ones. With SATURATE=1, te=0 and q holds at 0.
- LOAD: te = q ^ load_val, so q<=load_val next edge. tc<=0.
- tc:
  - Asserted for exactly one cycle: the cycle after an edge on which UP/DOWN with en=1 and clr=0 saw q at its boundary value.
  - This applies to both wrap and saturate. When saturated and held with en=1, tc re-asserts every cycle.
- ovf: set on the same edge tc is set; stays set until clr or reset.
- Mode changes take effect on the next edge. No pipeline: latency from inputs to q is 1 cycle.
- WIDTH=1: UP and DOWN both toggle the bit each cycle. The boundary is q=1 for UP and q=0 for DOWN.

Decomposition:
- Shared package t_ff_pkg holds:
  - mode localparams MODE_TOGGLE=2'b00, MODE_UP=2'b01, MODE_DOWN=2'b10, MODE_LOAD=2'b11;
  - a 2-bit mode_t typedef.
- One sub-module t_ff_cell: single-bit T flip-flop with ports clk, reset_n, rst_val, t, q, qb. It is instantiated WIDTH times in a generate loop.
- The top module holds the te-vector logic, tc and ovf.

Test Plan (WIDTH=4, RESET_VAL=0 unless stated):
- Reset then TOGGLE: t=4'b1010 for 2 en cycles gives q=1010 then 0000; qb=~q at every sample. Assert reset_n=0 mid-cycle and q=0 immediately, without waiting for a clock edge.
- UP wrap, SATURATE=0: 16 en cycles from 0 give q=1..15 then 0. tc=1 only in the cycle after q=15→0; ovf=1 afterwards.
- DOWN saturate, SATURATE=1: LOAD 4'h2, then DOWN 4 cycles gives q=1,0,0,0. tc=1 on each cycle after a hold at 0.
- en/clr priority: q=9 with en=0 for 3 cycles holds at 9. clr=1 with en=0 and ovf=1 gives q=0, ovf=0 next edge.
- LOAD then UP: load_val=4'hE, then UP 3 cycles gives q=E, F, 0, 1. tc pulses once after F→0.
- RESET_VAL=4'h5, WIDTH=1 build: after reset q=1 (bit 0 of RESET_VAL); UP gives 0, 1 with tc after 1→0.
